se_fetch_unit: RTL and testbench

//  Parametrised successor of the instruction-memory top: word-addressed instruction RAM with

---
 rtl/se_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_se_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/se_fetch_unit.sv
// Instruction fetch unit: word-addressed instruction RAM with a program-load port,
// PC sequencer with branch redirect, valid/ready delivery to decode, fault and fetch count.
module se_fetch_unit #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int DEPTH = 1024,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             loadEn_i,
  input  logic [XLEN-1:0]  loadAddr_i,
  input  logic [ILEN-1:0]  loadData_i,
  output logic             loadErr_o,
  input  logic             start_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirectPc_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [ILEN-1:0]  instr_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  nextPc_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] fetchCnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XLEN+1:0] MEM_BYTES = {XLEN'(DEPTH), 2'b00};
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  function automatic logic addr_ok(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < MEM_BYTES);
  endfunction

  logic [ILEN-1:0]  mem_r [DEPTH];
  state_t           state_r;
  logic             valid_r;
  logic             fault_r;
  logic             load_err_r;
  logic             pend_r;
  logic [XLEN-1:0]  pend_pc_r;
  logic [XLEN-1:0]  pc_r;
  logic [ILEN-1:0]  instr_r;
  logic [CNT_W-1:0] cnt_r;

  logic [XLEN:0]    seq_sum_s;
  logic             seq_ok_s;
  logic             load_ok_s;
  logic             redir_ok_s;
  logic             start_ok_s;
  logic             fire_s;
  logic             mem_we_s;
  logic [AW-1:0]    rd_idx_s;

  // A carry out of the sequential add is a 2^XLEN wrap and counts as a fault.
  assign seq_sum_s  = {1'b0, pc_r} + {1'b0, PC_STEP};
  assign seq_ok_s   = !seq_sum_s[XLEN] && addr_ok(seq_sum_s[XLEN-1:0]);
  assign load_ok_s  = addr_ok(loadAddr_i);
  assign redir_ok_s = addr_ok(redirectPc_i);
  assign start_ok_s = addr_ok(RESET_PC);
  assign fire_s     = valid_r & ready_i;
  assign mem_we_s   = loadEn_i && load_ok_s && ((state_r == ST_IDLE) || (state_r == ST_LOAD));
  assign rd_idx_s   = pend_r ? pend_pc_r[AW+1:2] : seq_sum_s[AW+1:2];

  // Program-load write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_r[loadAddr_i[AW+1:2]] <= loadData_i;
    end
  end

  // Control FSM; a pending target is read from RAM one edge after it is accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_IDLE;
      valid_r    <= 1'b0;
      fault_r    <= 1'b0;
      load_err_r <= 1'b0;
      pend_r     <= 1'b0;
      pend_pc_r  <= '0;
      pc_r       <= '0;
      instr_r    <= '0;
      cnt_r      <= '0;
    end else begin
      load_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (loadEn_i) begin
            state_r    <= ST_LOAD;
            load_err_r <= !load_ok_s;
          end else if (start_i && start_ok_s) begin
            state_r   <= ST_RUN;
            pend_r    <= 1'b1;
            pend_pc_r <= RESET_PC;
          end else if (start_i) begin
            state_r <= ST_FAULT;
            fault_r <= 1'b1;
            pc_r    <= RESET_PC;
          end
        end
        ST_LOAD: begin
          if (loadEn_i) begin
            load_err_r <= !load_ok_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (redirect_i) begin
            valid_r <= 1'b0;
            if (redir_ok_s) begin
              pend_r    <= 1'b1;
              pend_pc_r <= redirectPc_i;
            end else begin
              state_r <= ST_FAULT;
              fault_r <= 1'b1;
              pend_r  <= 1'b0;
              pc_r    <= redirectPc_i;
            end
          end else if (pend_r) begin
            pend_r  <= 1'b0;
            valid_r <= 1'b1;
            pc_r    <= pend_pc_r;
            instr_r <= mem_r[rd_idx_s];
          end else if (fire_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            pc_r  <= seq_sum_s[XLEN-1:0];
            if (seq_ok_s) begin
              instr_r <= mem_r[rd_idx_s];
            end else begin
              state_r <= ST_FAULT;
              valid_r <= 1'b0;
              fault_r <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          if (redirect_i && redir_ok_s) begin
            state_r   <= ST_RUN;
            fault_r   <= 1'b0;
            pend_r    <= 1'b1;
            pend_pc_r <= redirectPc_i;
          end else if (redirect_i) begin
            pc_r <= redirectPc_i;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          pend_r  <= 1'b0;
        end
      endcase
    end
  end

  assign loadErr_o  = load_err_r;
  assign valid_o    = valid_r;
  assign instr_o    = instr_r;
  assign pc_o       = pc_r;
  assign nextPc_o   = pc_r + PC_STEP;
  assign fault_o    = fault_r;
  assign fetchCnt_o = cnt_r;

endmodule

// File: tb/tb_se_fetch_unit.sv
// Bench for se_fetch_unit: directed scenarios plus randomized traffic, checked every cycle
// against a behavioural model of fetch, redirect, fault and load rules.
module tb_se_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        loadEn = 1'b0;
  logic [63:0] loadAddr = '0;
  logic [31:0] loadData = '0;
  logic        loadErr;
  logic        start = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirectPc = '0;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [63:0] nextPc;
  logic        fault;
  logic [31:0] fetchCnt;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  se_fetch_unit dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .loadEn_i(loadEn), .loadAddr_i(loadAddr), .loadData_i(loadData), .loadErr_o(loadErr),
    .start_i(start), .redirect_i(redirect), .redirectPc_i(redirectPc), .ready_i(ready),
    .valid_o(valid), .instr_o(instr), .pc_o(pc), .nextPc_o(nextPc),
    .fault_o(fault), .fetchCnt_o(fetchCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 load, 2 run, 3 fault.
  int          m_mode;
  bit          m_valid, m_fault, m_lerr, m_wait;
  logic [63:0] m_pc, m_wait_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_mem [1024];
  logic [31:0] ld_data [1024];

  function automatic bit legal(input logic [64:0] a);
    return (a[1:0] == 2'b00) && (a < 65'd4096);
  endfunction

  task automatic aim(input logic [63:0] t);
    if (legal({1'b0, t})) begin
      m_mode = 2; m_fault = 1'b0; m_wait = 1'b1; m_wait_pc = t;
    end else begin
      m_mode = 3; m_fault = 1'b1; m_valid = 1'b0; m_wait = 1'b0; m_pc = t;
    end
  endtask

  task automatic model_load();
    if (legal({1'b0, loadAddr})) m_mem[loadAddr[11:2]] = loadData;
    else m_lerr = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [64:0] nxt;
    if (!rst_n) begin
      m_mode = 0; m_valid = 1'b0; m_fault = 1'b0; m_lerr = 1'b0; m_wait = 1'b0;
      m_pc = '0; m_wait_pc = '0; m_cnt = '0;
    end else begin
      m_lerr = 1'b0;
      case (m_mode)
        0: if (loadEn) begin m_mode = 1; model_load(); end
           else if (start) aim(64'd0);
        1: if (loadEn) model_load(); else m_mode = 0;
        2: if (redirect) begin m_valid = 1'b0; aim(redirectPc); end
           else if (m_wait) begin m_wait = 1'b0; m_valid = 1'b1; m_pc = m_wait_pc; end
           else if (m_valid && ready) begin
             m_cnt = m_cnt + 32'd1;
             nxt = {1'b0, m_pc} + 65'd4;
             m_pc = nxt[63:0];
             if (!legal(nxt)) begin m_valid = 1'b0; m_mode = 3; m_fault = 1'b1; end
           end
        3: if (redirect) aim(redirectPc);
        default: m_mode = 0;
      endcase
    end
  end

  // Compare process: DUT against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", {63'd0, valid}, {63'd0, m_valid});
      chk("fault", {63'd0, fault}, {63'd0, m_fault});
      chk("loadErr", {63'd0, loadErr}, {63'd0, m_lerr});
      chk("fetchCnt", {32'd0, fetchCnt}, {32'd0, m_cnt});
      if (m_valid || m_fault) begin
        chk("pc", pc, m_pc);
        chk("nextPc", nextPc, m_pc + 64'd4);
      end
      if (m_valid) chk("instr", {32'd0, instr}, {32'd0, m_mem[m_pc[11:2]]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [63:0] t);
    int n = 0;
    while (!(valid && pc == t) && n < 2000) begin step(); n++; end
    chk("wait_pc", {63'd0, valid && (pc == t)}, 64'd1);
  endtask

  task automatic redir(input logic [63:0] t);
    redirect = 1'b1; redirectPc = t;
    step();
    redirect = 1'b0;
  endtask

  initial begin
    int n;
    int sel;
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_cnt", {32'd0, fetchCnt}, 64'd0);
    rst_n = 1'b1;
    step();

    // Full program load and sequential run-off.
    for (int i = 0; i < 1024; i++) begin
      ld_data[i] = $urandom;
      loadEn = 1'b1; loadAddr = 64'(i) * 64'd4; loadData = ld_data[i];
      step();
    end
    loadEn = 1'b0;
    step();
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    chk("start_lat_valid", {63'd0, valid}, 64'd0);
    step();
    chk("start_pc", pc, 64'd0);
    chk("start_instr", {32'd0, instr}, {32'd0, ld_data[0]});
    n = 0;
    while (!fault && n < 1100) begin step(); n++; end
    chk("runoff_fault", {63'd0, fault}, 64'd1);
    chk("runoff_pc", pc, 64'h1000);
    chk("runoff_cnt", {32'd0, fetchCnt}, 64'd1024);

    // Illegal redirect keeps FAULT; legal redirect resumes.
    redir(64'h202);
    chk("fault_hold", {63'd0, fault}, 64'd1);
    chk("fault_hold_pc", pc, 64'h202);
    redir(64'h0);
    chk("fault_clr", {63'd0, fault}, 64'd0);
    step();
    chk("resume_pc", pc, 64'h0);

    // Stall at 0x10.
    wait_pc(64'h10);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 64'h10);
      chk("stall_instr", {32'd0, instr}, {32'd0, ld_data[4]});
      chk("stall_cnt", {32'd0, fetchCnt}, 64'd1028);
    end
    ready = 1'b1;

    // Redirect beats a same-cycle handshake.
    wait_pc(64'h40);
    redir(64'h200);
    chk("redir_drop_valid", {63'd0, valid}, 64'd0);
    chk("redir_drop_cnt", {32'd0, fetchCnt}, 64'd1040);
    step();
    chk("redir_pc", pc, 64'h200);
    chk("redir_instr", {32'd0, instr}, {32'd0, ld_data[128]});

    // Misaligned redirect from RUN, then recovery.
    redir(64'h202);
    chk("mis_fault", {63'd0, fault}, 64'd1);
    redir(64'h8);
    chk("mis_clr", {63'd0, fault}, 64'd0);
    step();
    chk("mis_pc", pc, 64'h8);

    // Randomized traffic with ignored load/start noise.
    for (int i = 0; i < 600; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0: redirectPc = {50'd0, 10'($urandom_range(0, 1023)), 2'b10};
        1: redirectPc = 64'h2000;
        2: redirectPc = 64'($urandom_range(1016, 1023)) * 64'd4;
        default: redirectPc = 64'($urandom_range(0, 1023)) * 64'd4;
      endcase
      loadEn = ($urandom_range(0, 7) == 0);
      loadAddr = 64'($urandom_range(0, 1023)) * 64'd4;
      loadData = $urandom;
      start = ($urandom_range(0, 7) == 0);
      step();
    end
    redirect = 1'b0; loadEn = 1'b0; start = 1'b0; ready = 1'b1;

    // Asynchronous reset mid-RUN.
    redir(64'h0);
    repeat (3) step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", {63'd0, valid}, 64'd0);
    chk("areset_pc", pc, 64'd0);
    chk("areset_instr", {32'd0, instr}, 64'd0);
    chk("areset_cnt", {32'd0, fetchCnt}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Bad loads in IDLE, then load+start together.
    loadEn = 1'b1; loadAddr = 64'h1000; loadData = $urandom;
    step();
    chk("lerr_range", {63'd0, loadErr}, 64'd1);
    loadAddr = 64'h6; loadData = $urandom;
    step();
    chk("lerr_mis", {63'd0, loadErr}, 64'd1);
    loadEn = 1'b0;
    step();
    chk("lerr_clr", {63'd0, loadErr}, 64'd0);
    for (int i = 0; i < 12; i++) begin
      loadEn = ($urandom_range(0, 1) == 0);
      loadAddr = {52'd0, 10'($urandom_range(10, 1023)), 2'($urandom_range(0, 3))};
      loadData = $urandom;
      start = (i == 4);
      step();
    end
    loadEn = 1'b1; start = 1'b1; loadAddr = 64'h3000;
    step();
    loadEn = 1'b0; start = 1'b0;
    step();
    step();
    chk("load_wins", {63'd0, valid}, 64'd0);

    // Program intact after reset.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("restart_pc", pc, 64'h0);
    chk("restart_w0", {32'd0, instr}, {32'd0, ld_data[0]});
    step();
    chk("restart_w1", {32'd0, instr}, {32'd0, ld_data[1]});
    repeat (20) begin
      ready = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
